// File: rtl/niosII_sys_key_pkg.sv
// Shared constants and types for the key debounce / edge-capture controller.
// Optional KEY_CTRL_BOTH_EDGES_EN adds release capture and the edge-kind register.
package niosII_sys_key_pkg;

   localparam int KEY_WIDTH_DEF       = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 500000;

   localparam logic [1:0] ADDR_DATA      = 2'd0;
   localparam logic [1:0] ADDR_EDGE_KIND = 2'd1;
   localparam logic [1:0] ADDR_MASK      = 2'd2;
   localparam logic [1:0] ADDR_EDGE      = 2'd3;

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } deb_state_e;

endpackage

// File: rtl/niosII_sys_key_debounce.sv
// One key: two-flop synchroniser plus debounce FSM; emits the accepted level and
// single-cycle accept pulses. Rise pulse exists only with KEY_CTRL_BOTH_EDGES_EN.
module niosII_sys_key_debounce
   import niosII_sys_key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_pin,
   output logic o_level,
`ifdef KEY_CTRL_BOTH_EDGES_EN
   output logic o_rise,
`endif
   output logic o_fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1, r_sync2, r_level;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   deb_state_e       r_state, w_state_nxt;
   logic             w_level_nxt, w_accept;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b1;
         r_cnt   <= '0;
         r_state <= STABLE;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
         r_level <= w_level_nxt;
         r_cnt   <= w_cnt_nxt;
         r_state <= w_state_nxt;
      end
   end

   // Counter starts at 1 on entry so the accept lands exactly DEBOUNCE_CYCLES
   // edges after the synchroniser output changed.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_accept    = 1'b0;
      case (r_state)
         STABLE: begin
            w_cnt_nxt = '0;
            if (r_sync2 != r_level) begin
               w_state_nxt = PENDING;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         PENDING: begin
            if (r_sync2 == r_level) begin
               w_state_nxt = STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_accept    = 1'b1;
               w_level_nxt = r_sync2;
               w_state_nxt = STABLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_level = r_level;
   assign o_fall  = w_accept & ~r_sync2;
`ifdef KEY_CTRL_BOTH_EDGES_EN
   assign o_rise  = w_accept & r_sync2;
`endif

endmodule

// File: rtl/niosii_sys_key_ctrl.sv
// Debounced push-button controller with sticky edge capture, irq mask and Avalon-MM slave.
// Define KEY_CTRL_BOTH_EDGES_EN to also capture releases and expose the edge-kind register.
module niosii_sys_key_ctrl
   import niosII_sys_key_pkg::*;
#(
   parameter int WIDTH           = KEY_WIDTH_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] w_level, w_fall, w_event, w_w1c, w_edge_nxt;
   logic [WIDTH-1:0] r_mask, r_edge;
   logic [31:0]      r_readdata, w_rd_nxt;
   logic             r_irq, w_wr;
   logic             w_unused;

   assign w_wr     = chipselect & ~write_n;
   assign w_unused = &{1'b0, writedata[31:WIDTH]};

`ifdef KEY_CTRL_BOTH_EDGES_EN
   logic [WIDTH-1:0] w_rise, r_kind;
`endif

   for (genvar g = 0; g < WIDTH; g++) begin : g_key
      niosII_sys_key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_deb (
         .i_clk   (clk),
         .i_reset (reset),
         .i_pin   (in_port[g]),
         .o_level (w_level[g]),
`ifdef KEY_CTRL_BOTH_EDGES_EN
         .o_rise  (w_rise[g]),
`endif
         .o_fall  (w_fall[g])
      );
   end

`ifdef KEY_CTRL_BOTH_EDGES_EN
   assign w_event = w_fall | w_rise;
`else
   assign w_event = w_fall;
`endif

   // A new event on the same edge as a clear keeps the bit set.
   assign w_w1c      = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
   assign w_edge_nxt = (r_edge & ~w_w1c) | w_event;

   always_comb begin
      w_rd_nxt = '0;
      case (address)
         ADDR_DATA: w_rd_nxt[WIDTH-1:0] = w_level;
         ADDR_EDGE_KIND: begin
`ifdef KEY_CTRL_BOTH_EDGES_EN
            w_rd_nxt[WIDTH-1:0] = r_kind;
`endif
         end
         ADDR_MASK: w_rd_nxt[WIDTH-1:0] = r_mask;
         ADDR_EDGE: w_rd_nxt[WIDTH-1:0] = r_edge;
         default:   w_rd_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mask     <= '0;
         r_edge     <= '0;
         r_irq      <= 1'b0;
         r_readdata <= '0;
      end else begin
         if (w_wr && address == ADDR_MASK)
            r_mask <= writedata[WIDTH-1:0];
         r_edge     <= w_edge_nxt;
         r_irq      <= |(r_edge & r_mask);
         r_readdata <= w_rd_nxt;
      end
   end

`ifdef KEY_CTRL_BOTH_EDGES_EN
   // 1 = last accepted event on that key was a release.
   always_ff @(posedge clk) begin
      if (reset)
         r_kind <= '0;
      else
         r_kind <= (r_kind & ~w_event) | w_rise;
   end
`endif

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule

// File: tb/tb_niosii_sys_key_ctrl.sv
// Directed bench for niosii_sys_key_ctrl with a window-based reference model checked every cycle.
module tb_niosii_sys_key_ctrl;

   localparam int W = 4;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] in_port = '1;
   logic [1:0]   address = 2'd0;
   logic         chipselect = 1'b0;
   logic         write_n = 1'b1;
   logic [31:0]  writedata = '0;
   logic [31:0]  readdata;
   logic         irq;

   int total = 0;
   int bad   = 0;

   niosii_sys_key_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_port    (in_port),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Model: a key's level flips once the pin, seen two edges late, has disagreed
   // with the level on each of the last D edges.
   logic [W-1:0] hist [0:D+1];
   logic [W-1:0] m_level, m_mask, m_edge, m_kind;
   logic [31:0]  m_rd;
   logic         m_irq;
   bit           m_valid = 1'b0;

   always @(posedge clk) begin : model
      logic [W-1:0] acc, nlev, fall, rise, ev, clr;
      logic [31:0]  rd;
      bit           all;
      if (reset) begin
         for (int j = 0; j <= D + 1; j++) hist[j] = '1;
         m_level = '1; m_mask = '0; m_edge = '0; m_kind = '0;
         m_rd = '0; m_irq = 1'b0; m_valid = 1'b1;
      end else begin
         for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = in_port;
         acc = '0;
         for (int i = 0; i < W; i++) begin
            all = 1'b1;
            for (int j = 2; j <= D + 1; j++)
               if (hist[j][i] == m_level[i]) all = 1'b0;
            acc[i] = all;
         end
         nlev = m_level ^ acc;
         fall = acc & ~nlev;
         rise = acc & nlev;
`ifdef KEY_CTRL_BOTH_EDGES_EN
         ev = fall | rise;
`else
         ev = fall;
`endif
         rd = '0;
         case (address)
            2'd0: rd[W-1:0] = m_level;
            2'd1: begin
`ifdef KEY_CTRL_BOTH_EDGES_EN
               rd[W-1:0] = m_kind;
`endif
            end
            2'd2: rd[W-1:0] = m_mask;
            default: rd[W-1:0] = m_edge;
         endcase
         m_rd  = rd;
         m_irq = |(m_edge & m_mask);
         clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
         m_edge = (m_edge & ~clr) | ev;
         if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
         m_kind  = (m_kind & ~ev) | (rise & ev);
         m_level = nlev;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         total++;
         if (readdata !== m_rd) begin
            bad++;
            $display("FAIL model_readdata: got %h want %h at %0t", readdata, m_rd, $time);
         end
         total++;
         if (irq !== m_irq) begin
            bad++;
            $display("FAIL model_irq: got %b want %b at %0t", irq, m_irq, $time);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      tick(1);
      chk(name, readdata, exp);
   endtask

   // Edges until readdata (address 0) shows bit b at val; bounded at 40.
   task automatic wait_bit(input string name, input int b, input logic val, input int exp_n);
      int n;
      address = 2'd0;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (readdata[b] !== val && n < 40);
      chk(name, n, exp_n);
   endtask

   initial begin
      tick(3);
      chk("reset_readdata", readdata, 32'h0);
      chk("reset_irq", {31'b0, irq}, 32'h0);
      reset = 1'b0;

      rd_chk("t1_data", 2'd0, 32'hF);
      rd_chk("t1_kind", 2'd1, 32'h0);
      rd_chk("t1_mask", 2'd2, 32'h0);
      rd_chk("t1_edge", 2'd3, 32'h0);
      chk("t1_irq", {31'b0, irq}, 32'h0);
      wr(2'd0, 32'h0);
      wr(2'd1, 32'hFFFF_FFFF);
      rd_chk("ro_data", 2'd0, 32'hF);
      rd_chk("ro_kind", 2'd1, 32'h0);

      in_port[1] = 1'b0;
      wait_bit("t2_latency", 1, 1'b0, 11);
      rd_chk("t2_edge", 2'd3, 32'h2);
      chk("t2_irq_masked", {31'b0, irq}, 32'h0);

      in_port[1] = 1'b1;
      tick(12);
      wr(2'd3, 32'hF);
      wr(2'd2, 32'h2);
      rd_chk("t3_mask", 2'd2, 32'h2);
      in_port[1] = 1'b0;
      tick(10);
      chk("t3_irq_before", {31'b0, irq}, 32'h0);
      tick(1);
      chk("t3_irq_rise", {31'b0, irq}, 32'h1);
      rd_chk("t3_edge", 2'd3, 32'h2);
      wr(2'd3, 32'h2);
      chk("t3_irq_hold", {31'b0, irq}, 32'h1);
      tick(1);
      chk("t3_irq_drop", {31'b0, irq}, 32'h0);
      rd_chk("t3_edge_clr", 2'd3, 32'h0);
      in_port[1] = 1'b1;
      tick(12);
      wr(2'd3, 32'hF);

      repeat (4) begin
         in_port[0] = 1'b0;
         tick(5);
         in_port[0] = 1'b1;
         tick(3);
      end
      tick(4);
      rd_chk("t4_data", 2'd0, 32'hF);
      rd_chk("t4_edge", 2'd3, 32'h0);

      in_port[0] = 1'b0;
      tick(9);
      address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
      tick(1);
      chipselect = 1'b0; write_n = 1'b1;
      rd_chk("t5_set_wins", 2'd3, 32'h1);
      in_port[0] = 1'b1;
      tick(12);
      wr(2'd3, 32'hF);

      in_port[2] = 1'b0;
      tick(7);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      wait_bit("t6_latency", 2, 1'b0, 11);
      rd_chk("t6_edge", 2'd3, 32'h4);
      rd_chk("t6_mask", 2'd2, 32'h0);
      wr(2'd3, 32'hF);
      in_port[2] = 1'b1;
      tick(12);
`ifdef KEY_CTRL_BOTH_EDGES_EN
      rd_chk("t6_rel_edge", 2'd3, 32'h4);
      rd_chk("t6_kind", 2'd1, 32'h4);
`else
      rd_chk("t6_rel_edge", 2'd3, 32'h0);
      rd_chk("t6_kind", 2'd1, 32'h0);
`endif
      rd_chk("t6_data", 2'd0, 32'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/niosii_sys_key_ctrl.md
Name: niosII_sys_key_ctrl

Overview:
- Debounce and edge-capture controller for the push-button key inputs, with an Avalon-MM slave and a level interrupt to the Nios II.
- Synchronises the raw key pins and filters bounce per key.
- Latches press events into a sticky edge-capture register, masked onto irq.
- Sits between the board key pins and the system interconnect, in the same slot as the plain key PIO.

Parameters:
- WIDTH, 4, number of key inputs.
- DEBOUNCE_CYCLES, 500000, clock cycles an input must hold a new value before it is accepted (10 ms at 50 MHz); legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived).

Ports:
- clk  input  1  system clock; all logic in this single domain.
- reset  input  1  synchronous, active-high reset.
- in_port  input  WIDTH  raw key pins, active-low (0 = pressed); asynchronous to clk.
- address  input  2  Avalon word address.
- chipselect  input  1  Avalon select.
- write_n  input  1  Avalon write strobe, active-low, qualified by chipselect.
- writedata  input  32  Avalon write data.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt, active-high.

Behaviour:
- Register map:
  - 0: debounced key level, RO, bits [WIDTH-1:0].
  - 2: irq mask, RW.
  - 3: edge capture, write-1-to-clear.
  - 1: reads 0, writes ignored.
  - Unused upper bits read 0.
- Read: readdata is updated every cycle from address, with 1-cycle latency and no read strobe. It reflects register state as of the previous edge. Reset value 0.
- Write: takes effect when chipselect && !write_n, at the clock edge.
- Synchroniser: two flops per bit, both reset to 1 (released).
- Debounce, per bit, two states:
  - STABLE: sync == level; counter held at 0.
  - PENDING: sync != level; counter increments each cycle.
  - If sync returns to level before the count completes, go back to STABLE with counter 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still different, level <= sync, counter <= 0, state STABLE.
  - Accept latency from the synchroniser output changing: exactly DEBOUNCE_CYCLES cycles. Add 2 cycles for the synchroniser.
- Level reset value: all ones, so reset causes no spurious edge.
- Press event: debounced level goes 1->0 for that bit. It sets edge_capture[i] on the same edge at which level updates.
- Edge capture, same cycle as a W1C write:
  - If a new press and a write-1-clear hit the same bit, the set wins (bit = 1).
  - Bits written 0 are unchanged.
- irq = |(edge_capture & irq_mask), registered, so it asserts 1 cycle after edge_capture sets. Reset value 0.
- irq_mask and edge_capture reset to 0.
- Reset mid-debounce: counter, state and level return to their reset values. Any pending transition is discarded.
- Counter never wraps; it is bounded by DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: KEY_CTRL_BOTH_EDGES_EN.
- Defined: a debounced 0->1 (release) also sets the edge-capture bit. The level-at-accept is recorded in an extra RO register at address 1, bits [WIDTH-1:0], 1 = last event was a release.
- Undefined: only presses are captured and address 1 reads 0.

Decomposition:
- Shared package niosII_sys_key_pkg holds:
  - register address constants: ADDR_DATA = 0, ADDR_EDGE_KIND = 1, ADDR_MASK = 2, ADDR_EDGE = 3;
  - the debounce state enum {STABLE, PENDING};
  - default WIDTH and DEBOUNCE_CYCLES.
- One sub-module, niosII_sys_key_debounce: a single-bit synchroniser plus debounce FSM. It outputs level and a one-cycle fall pulse (and a rise pulse for the option), and is instantiated WIDTH times.
- The top holds the register file, read mux and irq.

Test Plan (all scenarios use DEBOUNCE_CYCLES = 8):
1. Reset, then read addresses 0/1/2/3 → 0x0000000F, 0, 0, 0; irq = 0.
2. Drive in_port[1] low and hold → level bit 1 drops exactly 10 cycles after the pin change (2 sync + 8 debounce). Edge reads 0x2. irq stays 0 while mask = 0.
3. Write mask 0x2, then press key 1 → irq rises 1 cycle after edge bit 1 sets. Write 0x2 to address 3 → edge reads 0 and irq drops the next cycle.
4. Toggle in_port[0] low for 5 cycles, high 3 cycles, repeated 4 times → level stays 1, edge = 0.
5. Schedule W1C 0x1 on the same edge that key 0's press is accepted → edge bit 0 reads 1.
6. Assert reset while key 2 is PENDING at count 5 → after release of reset with the pin still low, acceptance takes the full 10 cycles. With KEY_CTRL_BOTH_EDGES_EN, releasing key 2 then sets edge bit 2 and address 1 bit 2 reads 1.
